// File: rtl/maze_move_ctrl_pkg.sv
// maze_move_ctrl_pkg: shared encodings and geometry defaults for the maze move controller
package maze_move_ctrl_pkg;
    localparam logic [3:0] DIR_UP    = 4'b0001;
    localparam logic [3:0] DIR_DOWN  = 4'b0010;
    localparam logic [3:0] DIR_LEFT  = 4'b0100;
    localparam logic [3:0] DIR_RIGHT = 4'b1000;
    localparam logic [1:0] PH_DRAW   = 2'd0;
    localparam logic [1:0] PH_CLEAR  = 2'd1;
    localparam int DEF_GRID_COLS = 16;
    localparam int DEF_GRID_ROWS = 12;
    localparam int DEF_CELL_PX   = 10;
    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_CHECK, S_CLEAR, S_DRAW, S_DONE} state_t;
endpackage

// File: rtl/maze_move_ctrl_if.sv
// maze_move_ctrl_if: handshake bus between the move controller (master) and the box mover (slave)
interface maze_move_ctrl_if;
    logic [7:0] oX;
    logic [6:0] oY;
    logic [1:0] oPhase;
    logic       oMoveNow;
    logic       oFinalDone;
    logic       iDrawDone;
    modport master (output oX, oY, oPhase, oMoveNow, oFinalDone, input iDrawDone);
    modport slave  (input oX, oY, oPhase, oMoveNow, oFinalDone, output iDrawDone);
endinterface

// File: rtl/maze_dir_edge.sv
// maze_dir_edge: registered press detector, one-cycle pulse on a rising edge that leaves exactly one direction bit high
module maze_dir_edge (
    input  logic       iClock,
    input  logic       iResetn,
    input  logic [3:0] i_dir,
    output logic       o_press,
    output logic [3:0] o_dir
);
    logic [3:0] r_prev;
    // register the request and flag a new single-direction press
    always_ff @(posedge iClock) begin
        if (!iResetn) begin
            r_prev  <= '0;
            o_press <= 1'b0;
            o_dir   <= '0;
        end else begin
            r_prev  <= i_dir;
            o_press <= $onehot(i_dir) && |(i_dir & ~r_prev);
            o_dir   <= i_dir;
        end
    end
endmodule

// File: rtl/maze_move_ctrl.sv
// maze_move_ctrl: turns direction presses into wall-checked single-cell moves sequenced as CLEAR then DRAW
module maze_move_ctrl
    import maze_move_ctrl_pkg::*;
#(
    parameter int         GRID_COLS   = DEF_GRID_COLS,
    parameter int         GRID_ROWS   = DEF_GRID_ROWS,
    parameter int         CELL_PX     = DEF_CELL_PX,
    parameter int         X_ORIGIN    = 0,
    parameter int         Y_ORIGIN    = 0,
    parameter int         START_COL   = 0,
    parameter int         START_ROW   = 0,
    parameter int         GOAL_COL    = 15,
    parameter int         GOAL_ROW    = 11,
    parameter logic [7:0] STEP_BUDGET = 8'd99
) (
    input  logic             iClock,
    input  logic             iResetn,
    input  logic [3:0]       iDir,
    output logic [7:0]       oWallAddr,
    input  logic             iWallRdData,
    output logic [7:0]       oStepsLeft,
    output logic             oWin,
    output logic             oBlocked,
    maze_move_ctrl_if.master mv
);
    localparam logic [7:0] X_START = 8'(X_ORIGIN + START_COL * CELL_PX);
    localparam logic [6:0] Y_START = 7'(Y_ORIGIN + START_ROW * CELL_PX);
    localparam logic [7:0] DX      = 8'(CELL_PX);
    localparam logic [6:0] DY      = 7'(CELL_PX);
    localparam logic [3:0] COL0    = 4'(START_COL);
    localparam logic [3:0] ROW0    = 4'(START_ROW);

    logic       w_press;
    logic [3:0] w_dir;
    logic [3:0] w_tcol, w_trow;
    logic       w_out;
    logic [3:0] r_col, r_row, r_tcol, r_trow, r_mdir;
    state_t     r_state;

    maze_dir_edge u_edge (
        .iClock  (iClock),
        .iResetn (iResetn),
        .i_dir   (iDir),
        .o_press (w_press),
        .o_dir   (w_dir)
    );

    // target cell for the pending press and whether it leaves the grid
    always_comb begin
        w_tcol = w_dir == DIR_LEFT ? r_col - 4'd1 : w_dir == DIR_RIGHT ? r_col + 4'd1 : r_col;
        w_trow = w_dir == DIR_UP ? r_row - 4'd1 : w_dir == DIR_DOWN ? r_row + 4'd1 : r_row;
        w_out  = (w_dir == DIR_UP && r_row == 4'd0) ||
                 (w_dir == DIR_DOWN && r_row == 4'(GRID_ROWS - 1)) ||
                 (w_dir == DIR_LEFT && r_col == 4'd0) ||
                 (w_dir == DIR_RIGHT && r_col == 4'(GRID_COLS - 1));
    end

    // move sequencer: lookup, wall check, clear old cell, commit, draw new cell, end-of-game
    always_ff @(posedge iClock) begin
        if (!iResetn) begin
            r_state       <= S_IDLE;
            r_col         <= COL0;
            r_row         <= ROW0;
            r_tcol        <= COL0;
            r_trow        <= ROW0;
            r_mdir        <= '0;
            oWallAddr     <= {ROW0, COL0};
            oStepsLeft    <= STEP_BUDGET;
            oWin          <= 1'b0;
            oBlocked      <= 1'b0;
            mv.oX         <= X_START;
            mv.oY         <= Y_START;
            mv.oPhase     <= PH_DRAW;
            mv.oMoveNow   <= 1'b0;
            mv.oFinalDone <= 1'b0;
        end else begin
            mv.oMoveNow <= 1'b0;
            oBlocked    <= 1'b0;
            case (r_state)
                S_IDLE: if (w_press) begin
                    if (w_out) oBlocked <= 1'b1;
                    else begin
                        oWallAddr <= {w_trow, w_tcol};
                        r_tcol    <= w_tcol;
                        r_trow    <= w_trow;
                        r_mdir    <= w_dir;
                        r_state   <= S_LOOKUP;
                    end
                end
                S_LOOKUP: r_state <= S_CHECK;
                S_CHECK: if (iWallRdData) begin
                    oBlocked <= 1'b1;
                    r_state  <= S_IDLE;
                end else begin
                    mv.oPhase   <= PH_CLEAR;
                    mv.oMoveNow <= 1'b1;
                    r_state     <= S_CLEAR;
                end
                S_CLEAR: if (mv.iDrawDone) begin
                    r_col       <= r_tcol;
                    r_row       <= r_trow;
                    mv.oX       <= r_mdir == DIR_RIGHT ? mv.oX + DX : r_mdir == DIR_LEFT ? mv.oX - DX : mv.oX;
                    mv.oY       <= r_mdir == DIR_DOWN ? mv.oY + DY : r_mdir == DIR_UP ? mv.oY - DY : mv.oY;
                    oStepsLeft  <= oStepsLeft != 8'd0 ? oStepsLeft - 8'd1 : oStepsLeft;
                    mv.oPhase   <= PH_DRAW;
                    mv.oMoveNow <= 1'b1;
                    r_state     <= S_DRAW;
                end
                S_DRAW: if (mv.iDrawDone) begin
                    if (r_col == 4'(GOAL_COL) && r_row == 4'(GOAL_ROW)) begin
                        oWin          <= 1'b1;
                        mv.oFinalDone <= 1'b1;
                        r_state       <= S_DONE;
                    end else if (oStepsLeft == 8'd0) begin
                        mv.oFinalDone <= 1'b1;
                        r_state       <= S_DONE;
                    end else r_state <= S_IDLE;
                end
                default: r_state <= S_DONE;
            endcase
        end
    end
endmodule

// File: tb/tb_maze_move_ctrl.sv
// tb_maze_move_ctrl: directed and random presses against a cell-level model of the maze game
module tb_maze_move_ctrl;
    localparam logic [3:0] UP = 4'b0001, DOWN = 4'b0010, LEFT = 4'b0100, RIGHT = 4'b1000;

    logic       iClock = 1'b0;
    logic       iResetn = 1'b0;
    logic [3:0] iDir = '0;
    logic [7:0] oWallAddr;
    logic       iWallRdData;
    logic [7:0] oStepsLeft;
    logic       oWin, oBlocked;

    maze_move_ctrl_if mv();

    maze_move_ctrl dut (
        .iClock      (iClock),
        .iResetn     (iResetn),
        .iDir        (iDir),
        .oWallAddr   (oWallAddr),
        .iWallRdData (iWallRdData),
        .oStepsLeft  (oStepsLeft),
        .oWin        (oWin),
        .oBlocked    (oBlocked),
        .mv          (mv)
    );

    always #5 iClock = ~iClock;

    logic wall [256];
    bit   mover_en = 1'b1;
    int   dcnt;

    // wall ROM with one-cycle read latency
    always @(posedge iClock) iWallRdData <= wall[oWallAddr];

    // mover: answers each oMoveNow with a done pulse 1..4 cycles later
    always @(posedge iClock) begin
        mv.iDrawDone <= 1'b0;
        if (!iResetn) dcnt <= 0;
        else if (mv.oMoveNow && mover_en) dcnt <= int'($urandom_range(1, 4));
        else if (dcnt != 0) begin
            dcnt <= dcnt - 1;
            if (dcnt == 1) mv.iDrawDone <= 1'b1;
        end
    end

    int   n_tests = 0, n_fail = 0;
    int   m_col, m_row, m_steps;
    bit   m_done, m_win;
    logic [7:0] m_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_pos(input string tag);
        chk({tag, " x"}, 32'(mv.oX), 32'(m_col * 10));
        chk({tag, " y"}, 32'(mv.oY), 32'(m_row * 10));
        chk({tag, " steps"}, 32'(oStepsLeft), 32'(m_steps));
        chk({tag, " final"}, 32'(mv.oFinalDone), 32'(m_done));
        chk({tag, " win"}, 32'(oWin), 32'(m_win));
        chk({tag, " addr"}, 32'(oWallAddr), 32'(m_addr));
    endtask

    task automatic do_reset();
        iResetn = 1'b0;
        iDir = '0;
        @(negedge iClock);
        @(negedge iClock);
        m_col = 0; m_row = 0; m_steps = 99; m_done = 0; m_win = 0; m_addr = 8'h00;
        check_pos("reset");
        chk("reset phase", 32'(mv.oPhase), 0);
        chk("reset movenow", 32'(mv.oMoveNow), 0);
        chk("reset blocked", 32'(oBlocked), 0);
        iResetn = 1'b1;
    endtask

    task automatic press(input logic [3:0] d, input bit lat);
        int  tc, tr, mn, bl, tbl;
        bit  valid, inr, exp_mv, exp_bl, fin;
        valid  = $onehot(d) && !m_done;
        tc     = m_col + (d == RIGHT ? 1 : 0) - (d == LEFT ? 1 : 0);
        tr     = m_row + (d == DOWN ? 1 : 0) - (d == UP ? 1 : 0);
        inr    = tc >= 0 && tc < 16 && tr >= 0 && tr < 12;
        exp_mv = valid && inr && (inr ? !wall[tr * 16 + tc] : 1'b0);
        exp_bl = valid && !exp_mv;
        if (valid && inr) m_addr = 8'(tr * 16 + tc);
        mn = 0; bl = 0; tbl = 0; fin = 0;
        @(negedge iClock) iDir = d;
        @(negedge iClock) iDir = '0;
        for (int t = 1; t <= 80 && !fin; t++) begin
            @(negedge iClock);
            if (oBlocked) begin bl++; tbl = t; end
            if (mv.oMoveNow) begin
                mn++;
                if (mn == 1) begin
                    chk("clear phase", 32'(mv.oPhase), 1);
                    chk("clear x", 32'(mv.oX), 32'(m_col * 10));
                    chk("clear y", 32'(mv.oY), 32'(m_row * 10));
                    if (lat) chk("clear latency", 32'(t), 3);
                end else begin
                    chk("draw phase", 32'(mv.oPhase), 0);
                    chk("draw x", 32'(mv.oX), 32'(tc * 10));
                    chk("draw y", 32'(mv.oY), 32'(tr * 10));
                    chk("draw steps", 32'(oStepsLeft), 32'(m_steps - 1));
                end
            end
            if (mn == 2 && mv.iDrawDone) fin = 1;
            if (!exp_mv && t == 6) fin = 1;
        end
        chk("movenow count", 32'(mn), exp_mv ? 2 : 0);
        chk("blocked count", 32'(bl), 32'(exp_bl));
        if (exp_bl) chk("blocked time", 32'(tbl), inr ? 3 : 1);
        if (exp_mv) begin
            @(negedge iClock);
            m_col = tc;
            m_row = tr;
            if (m_steps > 0) m_steps--;
            if (m_col == 15 && m_row == 11) begin m_win = 1; m_done = 1; end
            else if (m_steps == 0) m_done = 1;
        end
        check_pos("after press");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit seen;
        for (int i = 0; i < 256; i++) wall[i] = 1'b0;
        do_reset();
        press(RIGHT, 1);
        do_reset();
        press(LEFT, 1);
        do_reset();
        wall[1] = 1'b1;
        press(RIGHT, 1);
        chk("wall addr", 32'(oWallAddr), 32'h01);
        wall[1] = 1'b0;
        do_reset();
        mover_en = 1'b0;
        @(negedge iClock) iDir = RIGHT;
        @(negedge iClock) iDir = '0;
        seen = 0;
        for (int t = 0; t < 10 && !seen; t++) begin
            @(negedge iClock);
            seen = mv.oMoveNow;
        end
        chk("midclear movenow seen", 32'(seen), 1);
        @(negedge iClock);
        @(negedge iClock);
        iResetn = 1'b0;
        @(negedge iClock);
        chk("midclear x", 32'(mv.oX), 0);
        chk("midclear steps", 32'(oStepsLeft), 99);
        chk("midclear phase", 32'(mv.oPhase), 0);
        chk("midclear movenow", 32'(mv.oMoveNow), 0);
        @(negedge iClock);
        chk("midclear movenow2", 32'(mv.oMoveNow), 0);
        iResetn = 1'b1;
        mover_en = 1'b1;
        m_col = 0; m_row = 0; m_steps = 99; m_done = 0; m_win = 0; m_addr = 8'h00;
        press(UP | RIGHT, 0);
        press(RIGHT, 0);
        for (int i = 1; i < 256; i++) wall[i] = ($urandom_range(0, 3) == 0);
        wall[0] = 1'b0;
        do_reset();
        for (int i = 0; i < 120; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            press(r < 8 ? 4'(1 << (r % 4)) : 4'($urandom_range(0, 15)), 0);
        end
        for (int i = 0; i < 256; i++) wall[i] = 1'b0;
        do_reset();
        for (int i = 0; i < 99; i++) press(i % 2 == 0 ? RIGHT : LEFT, 0);
        chk("budget final", 32'(mv.oFinalDone), 1);
        chk("budget win", 32'(oWin), 0);
        press(DOWN, 0);
        do_reset();
        for (int i = 0; i < 15; i++) press(RIGHT, 0);
        for (int i = 0; i < 11; i++) press(DOWN, 0);
        chk("goal win", 32'(oWin), 1);
        chk("goal x", 32'(mv.oX), 150);
        chk("goal y", 32'(mv.oY), 110);
        press(UP, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
